uart_command_receiver: RTL and testbench

- Upstream front-end of the controller's command interpreter.
- Assembles raw bytes from the UART RX core into 32-bit command words, received little-endian (byte0 first).
- Validates the opcode and presents the 3-bit command state plus a 24-bit operand to the interpreter over a valid/ready handshake.
- Detects illegal opcodes and overrun.

---
 rtl/uart_command_receiver_pkg.sv | 25 ++
 rtl/uart_command_receiver_byte_timeout_counter.sv | 33 +++
 rtl/uart_command_receiver.sv | 136 +++++++++++++
 tb/tb_uart_command_receiver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_command_receiver_pkg.sv
// Shared command encodings and word layout for the UART command receiver and interpreter.
package uart_command_receiver_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      PENDING = 1'b1
   } rx_state_e;

   localparam logic [2:0] CMD_IDLE                 = 3'd0;
   localparam logic [2:0] CMD_ESCREVER_UART        = 3'd1;
   localparam logic [2:0] CMD_RESET_PROCESSADOR    = 3'd2;
   localparam logic [2:0] CMD_LER_RESULTADO_ALU    = 3'd3;
   localparam logic [2:0] CMD_LER_REGISTRADOR      = 3'd4;
   localparam logic [2:0] CMD_ESCREVER_REGISTRADOR = 3'd5;
   localparam logic [2:0] CMD_LER_MEMORIA          = 3'd6;
   localparam logic [2:0] CMD_ESCREVER_MEMORIA     = 3'd7;

   localparam int OPCODE_LSB  = 0;
   localparam int OPCODE_MSB  = 7;
   localparam int OPERAND_LSB = 8;
   localparam int OPERAND_MSB = 31;

   localparam logic [7:0] ILLEGAL_OPCODE_MASK = 8'hF8;

endpackage

// File: rtl/uart_command_receiver_byte_timeout_counter.sv
// Inter-byte timeout counter; expired is high once TIMEOUT_CYCLES-1 idle cycles have elapsed.
module byte_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   input  logic enable,
   output logic expired
);

   localparam int unsigned W = $clog2(TIMEOUT_CYCLES);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (restart || !enable) begin
         cnt_d = '0;
      end else if (cnt_q != LAST) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expired = enable && !restart && (cnt_q == LAST);

endmodule

// File: rtl/uart_command_receiver.sv
// Assembles little-endian 32-bit command words from UART bytes and presents them over valid/ready.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module uart_command_receiver
   import uart_command_receiver_pkg::*;
#(
   parameter int unsigned CLK_FREQ       = 25000000,
   parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [2:0]  cmd_state,
   output logic [23:0] cmd_operand,
   output logic        illegal_cmd,
   output logic        overrun,
   input  logic        clear_overrun,
   output logic [1:0]  byte_count
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   rx_state_e   state_q, state_d;
   logic [1:0]  byte_count_q, byte_count_d;
   logic [23:0] word_q, word_d;
   logic [2:0]  cmd_state_q, cmd_state_d;
   logic [23:0] cmd_operand_q, cmd_operand_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic        illegal_q, illegal_d;
   logic        overrun_q, overrun_d;
   logic        timeout_expired;
   logic [31:0] full_word;

`ifdef CMD_TIMEOUT_EN
   byte_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .restart(rx_valid),
      .enable ((state_q == COLLECT) && (byte_count_q != 2'd0)),
      .expired(timeout_expired)
   );
`else
   assign timeout_expired = 1'b0;
`endif

   // The 4th byte is checked together with the three buffered lanes at the same edge.
   assign full_word = {rx_data, word_q};

   always_comb begin
      state_d       = state_q;
      byte_count_d  = byte_count_q;
      word_d        = word_q;
      cmd_state_d   = cmd_state_q;
      cmd_operand_d = cmd_operand_q;
      cmd_valid_d   = cmd_valid_q;
      illegal_d     = 1'b0;
      overrun_d     = clear_overrun ? 1'b0 : overrun_q;

      case (state_q)
         COLLECT: begin
            if (rx_valid) begin
               case (byte_count_q)
                  2'd0: word_d[7:0]   = rx_data;
                  2'd1: word_d[15:8]  = rx_data;
                  2'd2: word_d[23:16] = rx_data;
                  default: ;
               endcase
               if (byte_count_q == 2'd3) begin
                  byte_count_d = 2'd0;
                  if ((full_word[OPCODE_MSB:OPCODE_LSB] & ILLEGAL_OPCODE_MASK) != 8'd0) begin
                     illegal_d = 1'b1;
                  end else begin
                     cmd_state_d   = full_word[OPCODE_LSB+2:OPCODE_LSB];
                     cmd_operand_d = full_word[OPERAND_MSB:OPERAND_LSB];
                     cmd_valid_d   = 1'b1;
                     state_d       = PENDING;
                  end
               end else begin
                  byte_count_d = byte_count_q + 2'd1;
               end
            end else if (timeout_expired) begin
               byte_count_d = 2'd0;
            end
         end
         PENDING: begin
            if (cmd_valid_q && cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = COLLECT;
               if (rx_valid) begin
                  word_d[7:0]  = rx_data;
                  byte_count_d = 2'd1;
               end
            end else if (rx_valid) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= COLLECT;
         byte_count_q  <= '0;
         word_q        <= '0;
         cmd_state_q   <= CMD_IDLE;
         cmd_operand_q <= '0;
         cmd_valid_q   <= 1'b0;
         illegal_q     <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_count_q  <= byte_count_d;
         word_q        <= word_d;
         cmd_state_q   <= cmd_state_d;
         cmd_operand_q <= cmd_operand_d;
         cmd_valid_q   <= cmd_valid_d;
         illegal_q     <= illegal_d;
         overrun_q     <= overrun_d;
      end
   end

   assign cmd_valid   = cmd_valid_q;
   assign cmd_state   = cmd_state_q;
   assign cmd_operand = cmd_operand_q;
   assign illegal_cmd = illegal_q;
   assign overrun     = overrun_q;
   assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_uart_command_receiver.sv
// Directed self-checking bench for uart_command_receiver.
module tb_uart_command_receiver;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [2:0]  cmd_state;
   logic [23:0] cmd_operand;
   logic        illegal_cmd;
   logic        overrun;
   logic        clear_overrun = 1'b0;
   logic [1:0]  byte_count;

   int total = 0;
   int bad   = 0;

   uart_command_receiver #(
      .CLK_FREQ      (25000000),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_state    (cmd_state),
      .cmd_operand  (cmd_operand),
      .illegal_cmd  (illegal_cmd),
      .overrun      (overrun),
      .clear_overrun(clear_overrun),
      .byte_count   (byte_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      tick();
      tick();
      check("rst_valid",   {31'd0, cmd_valid},   32'd0);
      check("rst_state",   {29'd0, cmd_state},   32'd0);
      check("rst_operand", {8'd0, cmd_operand},  32'd0);
      check("rst_illegal", {31'd0, illegal_cmd}, 32'd0);
      check("rst_overrun", {31'd0, overrun},     32'd0);
      check("rst_count",   {30'd0, byte_count},  32'd0);
      reset = 1'b0;
      tick();

      // legal word accepted immediately
      cmd_ready = 1'b1;
      send_byte(8'h05);
      check("t1_count1", {30'd0, byte_count}, 32'd1);
      send_byte(8'h34);
      send_byte(8'h12);
      check("t1_count3", {30'd0, byte_count}, 32'd3);
      check("t1_novalid", {31'd0, cmd_valid}, 32'd0);
      send_byte(8'hAB);
      check("t1_valid",   {31'd0, cmd_valid},  32'd1);
      check("t1_state",   {29'd0, cmd_state},  32'd5);
      check("t1_operand", {8'd0, cmd_operand}, 32'h00AB1234);
      check("t1_overrun", {31'd0, overrun},    32'd0);
      check("t1_count0",  {30'd0, byte_count}, 32'd0);
      tick();
      check("t1_valid_drop", {31'd0, cmd_valid}, 32'd0);

      // illegal opcode then a legal word
      send_byte(8'h09);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      check("t2_illegal",   {31'd0, illegal_cmd}, 32'd1);
      check("t2_novalid",   {31'd0, cmd_valid},   32'd0);
      check("t2_count",     {30'd0, byte_count},  32'd0);
      tick();
      check("t2_ill_pulse", {31'd0, illegal_cmd}, 32'd0);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      check("t2_valid",   {31'd0, cmd_valid},  32'd1);
      check("t2_state",   {29'd0, cmd_state},  32'd2);
      check("t2_illegal0", {31'd0, illegal_cmd}, 32'd0);
      tick();
      check("t2_drop",    {31'd0, cmd_valid},  32'd0);

      // pending word with overrun, clear, then accept
      cmd_ready = 1'b0;
      send_byte(8'h06);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      check("t3_valid", {31'd0, cmd_valid}, 32'd1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      check("t3_overrun", {31'd0, overrun},    32'd1);
      check("t3_state",   {29'd0, cmd_state},  32'd6);
      check("t3_operand", {8'd0, cmd_operand}, 32'h00030201);
      check("t3_count",   {30'd0, byte_count}, 32'd0);
      check("t3_still",   {31'd0, cmd_valid},  32'd1);
      clear_overrun = 1'b1;
      tick();
      clear_overrun = 1'b0;
      check("t3_cleared", {31'd0, overrun}, 32'd0);
      // clear and a new overrun in the same cycle: set wins
      clear_overrun = 1'b1;
      send_byte(8'hCC);
      clear_overrun = 1'b0;
      check("t3_setwins", {31'd0, overrun}, 32'd1);
      clear_overrun = 1'b1;
      tick();
      clear_overrun = 1'b0;
      cmd_ready = 1'b1;
      tick();
      check("t3_accept", {31'd0, cmd_valid},  32'd0);
      check("t3_count0", {30'd0, byte_count}, 32'd0);
      check("t3_ovr0",   {31'd0, overrun},    32'd0);

      // handshake with simultaneous byte
      cmd_ready = 1'b0;
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      check("t4_valid", {31'd0, cmd_valid}, 32'd1);
      check("t4_state", {29'd0, cmd_state}, 32'd1);
      cmd_ready = 1'b1;
      send_byte(8'h07);
      check("t4_hs_valid", {31'd0, cmd_valid},  32'd0);
      check("t4_hs_count", {30'd0, byte_count}, 32'd1);
      check("t4_hs_ovr",   {31'd0, overrun},    32'd0);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h00);
      check("t4_valid2",  {31'd0, cmd_valid},  32'd1);
      check("t4_state2",  {29'd0, cmd_state},  32'd7);
      check("t4_operand", {8'd0, cmd_operand}, 32'h00000001);
      tick();
      check("t4_drop", {31'd0, cmd_valid}, 32'd0);

      // reset mid-word and mid-pending
      cmd_ready = 1'b0;
      send_byte(8'h55);
      send_byte(8'h66);
      check("t5_count2", {30'd0, byte_count}, 32'd2);
      reset = 1'b1;
      #1;
      check("t5_rst_count", {30'd0, byte_count}, 32'd0);
      tick();
      reset = 1'b0;
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      check("t5_valid",   {31'd0, cmd_valid},  32'd1);
      check("t5_state",   {29'd0, cmd_state},  32'd3);
      check("t5_operand", {8'd0, cmd_operand}, 32'h00000000);
      #2;
      reset = 1'b1;
      #1;
      check("t5_rst_valid", {31'd0, cmd_valid}, 32'd0);
      check("t5_rst_state", {29'd0, cmd_state}, 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // ready without valid is ignored
      cmd_ready = 1'b1;
      tick();
      check("t6_ready_idle", {31'd0, cmd_valid}, 32'd0);
      cmd_ready = 1'b0;

`ifdef CMD_TIMEOUT_EN
      send_byte(8'h77);
      send_byte(8'h88);
      check("t7_count2", {30'd0, byte_count}, 32'd2);
      for (int i = 0; i < 20; i++) tick();
      check("t7_timeout", {30'd0, byte_count},  32'd0);
      check("t7_noill",   {31'd0, illegal_cmd}, 32'd0);
      check("t7_noval",   {31'd0, cmd_valid},   32'd0);
      send_byte(8'h04);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
`else
      send_byte(8'h04);
      send_byte(8'h11);
      for (int i = 0; i < 20; i++) tick();
      check("t7_hold", {30'd0, byte_count}, 32'd2);
      send_byte(8'h22);
      send_byte(8'h33);
`endif
      check("t7_valid",   {31'd0, cmd_valid},  32'd1);
      check("t7_state",   {29'd0, cmd_state},  32'd4);
      check("t7_operand", {8'd0, cmd_operand}, 32'h00332211);
      cmd_ready = 1'b1;
      tick();
      check("t7_drop", {31'd0, cmd_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
